// File: rtl/oam_dma_bus_ctrl.sv
// rtl/oam_dma_bus_ctrl.sv - SM83 bus arbiter with OAM DMA engine
// Optional macro OAM_DMA_CPU_STALL_EN adds cpu_wait to hold blocked CPU accesses.
module oam_dma_bus_ctrl #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_DST      = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          START_DELAY  = 1,
  parameter logic [7:0]  BLOCKED_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
`ifdef OAM_DMA_CPU_STALL_EN
  output logic        cpu_wait,
`endif
  output logic        dma_active
);

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  state_t        state, state_nxt;
  logic [8:0]    idx, idx_nxt;
  logic [DW-1:0] dly_cnt, dly_nxt;
  logic [7:0]    dma_page;
  logic [7:0]    rdata_q;
  logic          fwd_q;

  logic reg_hit, hram_hit, cpu_acc, reg_wr, reg_rd, fwd, fwd_rd;

  assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
  assign hram_hit = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign cpu_acc  = cpu_rd || cpu_wr;
  assign reg_wr   = cpu_wr && reg_hit;
  assign reg_rd   = cpu_rd && !cpu_wr && reg_hit;
  // Forwarding is gated by rst_n so the bus is quiet for the whole reset window.
  assign fwd      = rst_n && (state == IDLE) && cpu_acc && !reg_hit && !hram_hit;
  assign fwd_rd   = fwd && cpu_rd && !cpu_wr;

  assign dma_active = (state != IDLE);

`ifdef OAM_DMA_CPU_STALL_EN
  assign cpu_wait = (state != IDLE) && cpu_acc && !reg_hit && !hram_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      dly_cnt  <= '0;
      dma_page <= 8'h00;
      fwd_q    <= 1'b0;
      rdata_q  <= BLOCKED_DATA;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      dly_cnt  <= dly_nxt;
      if (reg_wr) dma_page <= cpu_wdata;
      fwd_q    <= fwd_rd;
      rdata_q  <= reg_rd ? dma_page : BLOCKED_DATA;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dly_nxt   = dly_cnt;
    case (state)
      IDLE: ;
      START: begin
        if (dly_cnt == DW'(START_DELAY - 1)) state_nxt = READ;
        else dly_nxt = dly_cnt + 1'b1;
      end
      READ: state_nxt = WRITE;
      WRITE: begin
        if (idx < 9'(DMA_LEN - 1)) begin
          state_nxt = READ;
          idx_nxt   = idx + 9'd1;
        end else begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A register write (re)starts the transfer from any state.
    if (reg_wr) begin
      state_nxt = START;
      idx_nxt   = '0;
      dly_nxt   = '0;
    end
  end

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      READ: begin
        mem_addr = {dma_page, idx[7:0]};
        mem_rd   = 1'b1;
      end
      WRITE: begin
        mem_addr  = DMA_DST + {7'b0, idx};
        mem_wdata = mem_rdata;
        mem_wr    = 1'b1;
      end
      default: begin
        if (fwd) begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_wr    = cpu_wr;
          mem_rd    = cpu_rd && !cpu_wr;
        end
      end
    endcase
  end

  assign cpu_rdata = fwd_q ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// tb/tb_oam_dma_bus_ctrl.sv - self-checking bench for oam_dma_bus_ctrl
module tb_oam_dma_bus_ctrl;
    localparam int LEN = 160;
    localparam int SD  = 1;
    localparam int LAST = SD + 2 * LEN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dma_active;
`ifdef OAM_DMA_CPU_STALL_EN
    logic        cpu_wait;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;
    logic [7:0]  src [0:LEN-1];

    always #5 clk = ~clk;

    oam_dma_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata),
`ifdef OAM_DMA_CPU_STALL_EN
        .cpu_wait(cpu_wait),
`endif
        .dma_active(dma_active)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick;
        pre_we = 1'b0;
    endtask

    task automatic load_src(input logic [7:0] page, input bit rnd);
        for (int i = 0; i < LEN; i++) begin
            src[i] = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
            load({page, 8'(i)}, src[i]);
        end
    endtask

    task automatic start_dma(input logic [7:0] page);
        cpu_addr = 16'hFF46; cpu_wdata = page; cpu_wr = 1'b1; cpu_rd = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_in;
        repeat (3) tick;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dma_active, mem_rd, mem_wr} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got %b exp 000", {dma_active, mem_rd, mem_wr});
        end
        checks++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus: got %h/%h exp 0000/00", mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_rdata !== 8'hFF) begin
            failures++;
            $display("FAIL reset_rdata: got %h exp ff", cpu_rdata);
        end
        tick;
    endtask

    task automatic test_basic_copy;
        load_src(8'hC0, 1'b0);
        start_dma(8'hC0);
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || dma_active !== 1'b0) begin
            failures++;
            $display("FAIL basic_reg_write_not_forwarded: got wr=%b rd=%b act=%b exp 0 0 0", mem_wr, mem_rd, dma_active);
        end
        tick;
        idle_in;
        for (int k = 1; k <= LAST + 4; k++) begin
            int j, i;
            bit e_rd, e_wr, e_act;
            @(negedge clk);
            j = k - 1 - SD;
            i = j / 2;
            e_act = (k <= LAST);
            e_rd = (j >= 0) && (j % 2 == 0) && (i < LEN);
            e_wr = (j >= 1) && (j % 2 == 1) && (i < LEN);
            checks++;
            if (dma_active !== e_act) begin
                failures++;
                $display("FAIL basic_active k=%0d: got %b exp %b", k, dma_active, e_act);
            end
            checks++;
            if (mem_rd !== e_rd || mem_wr !== e_wr) begin
                failures++;
                $display("FAIL basic_strobes k=%0d: got rd=%b wr=%b exp rd=%b wr=%b", k, mem_rd, mem_wr, e_rd, e_wr);
            end
            if (e_rd) begin
                checks++;
                if (mem_addr !== {8'hC0, 8'(i)}) begin
                    failures++;
                    $display("FAIL basic_src_addr i=%0d: got %h exp %h", i, mem_addr, {8'hC0, 8'(i)});
                end
            end
            if (e_wr) begin
                checks++;
                if (mem_addr !== 16'hFE00 + 16'(i) || mem_wdata !== src[i]) begin
                    failures++;
                    $display("FAIL basic_dst i=%0d: got %h=%h exp %h=%h", i, mem_addr, mem_wdata, 16'hFE00 + 16'(i), src[i]);
                end
            end
            tick;
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== src[i]) begin
                failures++;
                $display("FAIL basic_oam i=%0d: got %h exp %h", i, mem[16'hFE00 + 16'(i)], src[i]);
            end
        end
    endtask

    task automatic test_passthrough;
        logic [7:0] r, w;
        r = 8'($urandom);
        w = 8'($urandom);
        load(16'h0010, r);
        cpu_addr = 16'h0010; cpu_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
            failures++;
            $display("FAIL pass_rd_fwd: got rd=%b wr=%b addr=%h exp 1 0 0010", mem_rd, mem_wr, mem_addr);
        end
        tick; idle_in;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== r) begin
            failures++;
            $display("FAIL pass_rdata: got %h exp %h", cpu_rdata, r);
        end
        tick;
        cpu_addr = 16'hC200; cpu_wdata = w; cpu_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 16'hC200 || mem_wdata !== w) begin
            failures++;
            $display("FAIL pass_wr_fwd: got wr=%b %h=%h exp 1 c200=%h", mem_wr, mem_addr, mem_wdata, w);
        end
        tick; idle_in;
        checks++;
        if (mem[16'hC200] !== w) begin
            failures++;
            $display("FAIL pass_wr_mem: got %h exp %h", mem[16'hC200], w);
        end
        cpu_addr = 16'hFF90; cpu_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL hram_not_fwd: got rd=%b exp 0", mem_rd);
        end
        tick; idle_in;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'hFF) begin
            failures++;
            $display("FAIL hram_rdata: got %h exp ff", cpu_rdata);
        end
        tick;
        cpu_addr = 16'hC300; cpu_wdata = 8'h3C; cpu_rd = 1'b1; cpu_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL rdwr_both: got rd=%b wr=%b exp rd=0 wr=1", mem_rd, mem_wr);
        end
        tick; idle_in;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'hFF) begin
            failures++;
            $display("FAIL rdwr_rdata: got %h exp ff", cpu_rdata);
        end
        tick;
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL reg_rd_not_fwd: got rd=%b exp 0", mem_rd);
        end
        tick; idle_in;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'hC0) begin
            failures++;
            $display("FAIL reg_rd_idle: got %h exp c0", cpu_rdata);
        end
        tick;
    endtask

    task automatic test_blocked;
        bit         prev_rd;
        logic [7:0] prev_exp;
        load(16'hD000, 8'hAA);
        load_src(8'hC1, 1'b1);
        start_dma(8'hC1);
        tick; idle_in;
        prev_rd = 1'b0;
        prev_exp = 8'hFF;
        for (int k = 1; k <= LAST + 4; k++) begin
            int j, i, op;
            bit e_rd, e_wr, cur_rd;
            logic [7:0] cur_exp;
            cur_rd = 1'b0; cur_exp = 8'hFF;
            if (k == 10) begin
                cpu_addr = 16'hC123; cpu_rd = 1'b1; cur_rd = 1'b1;
            end else if (k == 20) begin
                cpu_addr = 16'hD000; cpu_wdata = 8'h77; cpu_wr = 1'b1;
            end else if (k == 30) begin
                cpu_addr = 16'hFF46; cpu_rd = 1'b1; cur_rd = 1'b1; cur_exp = 8'hC1;
            end else if (k < 300) begin
                op = int'($urandom_range(0, 2));
                if (op == 1) begin
                    cpu_addr = {1'b0, 15'($urandom)}; cpu_rd = 1'b1; cur_rd = 1'b1;
                end else if (op == 2) begin
                    cpu_addr = 16'h8000 | 16'($urandom_range(0, 4095)); cpu_wdata = 8'($urandom); cpu_wr = 1'b1;
                end
            end
            @(negedge clk);
            j = k - 1 - SD;
            i = j / 2;
            e_rd = (j >= 0) && (j % 2 == 0) && (i < LEN);
            e_wr = (j >= 1) && (j % 2 == 1) && (i < LEN);
            checks++;
            if (mem_rd !== e_rd || mem_wr !== e_wr) begin
                failures++;
                $display("FAIL blk_strobes k=%0d: got rd=%b wr=%b exp rd=%b wr=%b", k, mem_rd, mem_wr, e_rd, e_wr);
            end
            if (e_rd || e_wr) begin
                checks++;
                if (mem_addr !== (e_rd ? {8'hC1, 8'(i)} : 16'hFE00 + 16'(i))) begin
                    failures++;
                    $display("FAIL blk_addr k=%0d: got %h", k, mem_addr);
                end
            end
            if (prev_rd) begin
                checks++;
                if (cpu_rdata !== prev_exp) begin
                    failures++;
                    $display("FAIL blk_rdata k=%0d: got %h exp %h", k, cpu_rdata, prev_exp);
                end
            end
            prev_rd = cur_rd;
            prev_exp = cur_exp;
            tick; idle_in;
        end
        checks++;
        if (mem[16'hD000] !== 8'hAA) begin
            failures++;
            $display("FAIL blk_write_dropped: got %h exp aa", mem[16'hD000]);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== src[i]) begin
                failures++;
                $display("FAIL blk_oam i=%0d: got %h exp %h", i, mem[16'hFE00 + 16'(i)], src[i]);
            end
        end
    endtask

    task automatic test_restart;
        load_src(8'hD0, 1'b1);
        start_dma(8'hC0);
        tick; idle_in;
        for (int k = 1; k <= 102; k++) begin
            if (k == 102) start_dma(8'hD0);
            @(negedge clk);
            checks++;
            if (dma_active !== 1'b1) begin
                failures++;
                $display("FAIL rst1_active k=%0d: got %b exp 1", k, dma_active);
            end
            if (k == 102) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== 16'hC032) begin
                    failures++;
                    $display("FAIL restart_cur_strobe: got rd=%b addr=%h exp 1 c032", mem_rd, mem_addr);
                end
            end
            tick; idle_in;
        end
        for (int k = 1; k <= LAST + 4; k++) begin
            @(negedge clk);
            checks++;
            if (dma_active !== (k <= LAST)) begin
                failures++;
                $display("FAIL rst2_active k=%0d: got %b", k, dma_active);
            end
            if (k == 1 + SD) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== 16'hD000) begin
                    failures++;
                    $display("FAIL restart_first_rd: got rd=%b addr=%h exp 1 d000", mem_rd, mem_addr);
                end
            end
            tick;
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== src[i]) begin
                failures++;
                $display("FAIL restart_oam i=%0d: got %h exp %h", i, mem[16'hFE00 + 16'(i)], src[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        start_dma(8'hC0);
        tick; idle_in;
        repeat (81) tick;
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'hC028) begin
            failures++;
            $display("FAIL mid_pre_read: got rd=%b addr=%h exp 1 c028", mem_rd, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dma_active, mem_rd, mem_wr} !== 3'b000 || mem_addr !== 16'h0 || mem_wdata !== 8'h0 || cpu_rdata !== 8'hFF) begin
            failures++;
            $display("FAIL mid_reset_vals: got act=%b rd=%b wr=%b %h %h %h exp 0 0 0 0000 00 ff",
                     dma_active, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rdata);
        end
        tick; tick;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({dma_active, mem_rd, mem_wr} !== 3'b000) begin
                failures++;
                $display("FAIL mid_quiet k=%0d: got act=%b rd=%b wr=%b", k, dma_active, mem_rd, mem_wr);
            end
            tick;
        end
    endtask

    initial begin
        idle_in;
        rst_n = 1'b0;
        test_reset;
        test_basic_copy;
        test_passthrough;
        test_blocked;
        test_restart;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
